multicycle_ctrl: RTL and testbench

Main control finite-state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, address/execute, memory and write-back steps per instruction, and drives every datapath enable and mux select. It also supplies the 2-bit `alu_op` consumed by the ALU control decoder, using the encoding 00 = add, 01 = subtract, 10 = use funct field. It sits between the instruction register opcode field and the datapath, and stalls on a memory ready handshake.

---
 rtl/mc_pkg.sv | 72 +++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/mc_output_decode.sv | 84 ++++++++
 rtl/multicycle_ctrl.sv | 86 ++++++++
 tb/tb_multicycle_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control FSM.
// The optional addi path is enabled by defining MC_ADDI_EN.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
`ifdef MC_ADDI_EN
    ,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Moore portion of the control word; illegal_op is added by the top.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BEQ)   || (op == OP_J);
`ifdef MC_ADDI_EN
    legal = legal || (op == OP_ADDI);
`endif
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control word for each FSM state, with mem_ready qualifying
// the fetch load strobes and the store completion pulse.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: default the whole word first so no path through the case infers a latch.
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// next-state logic; outputs come from mc_output_decode. Optional: MC_ADDI_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  state_t     state;
  state_t     state_next;
  logic [5:0] op_q;
  logic       illegal;
  ctrl_t      ctrl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_next;
  end

  // NOTE: op_q needs no reset; it is only read in MEMADR, reachable solely through DECODE.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) op_q <= bus.opcode;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_next = S_ADDIEX;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
`endif
      default:  state_next = S_RESET;
    endcase
  end

  // An unsupported opcode ends the instruction in DECODE itself.
  assign illegal = (state == S_DECODE) && !is_legal_op(bus.opcode);

  mc_output_decode u_output_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = illegal;
  assign bus.instr_done    = ctrl.instr_done | illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected control words are queued as
// each cycle's stimulus is driven and compared mid-cycle on the falling edge.
module tb_multicycle_ctrl;

  localparam int K_RESET  = 0;
  localparam int K_FETCH  = 1;
  localparam int K_DECODE = 2;
  localparam int K_MEMADR = 3;
  localparam int K_MEMRD  = 4;
  localparam int K_MEMWB  = 5;
  localparam int K_MEMWR  = 6;
  localparam int K_EXEC   = 7;
  localparam int K_RWB    = 8;
  localparam int K_BRANCH = 9;
  localparam int K_JUMP   = 10;
  localparam int K_ADDIEX = 11;
  localparam int K_ADDIWB = 12;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: pc_write pc_write_cond iord mem_read mem_write ir_write mem_to_reg
  // reg_dst reg_write alu_src_a alu_src_b[2] alu_op[2] pc_source[2] illegal_op instr_done
  function automatic logic [17:0] exp_vec(input int kind, input logic rdy, input logic [5:0] op);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, done;
    logic [1:0] sb, aop, psrc;
    logic legal;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, done} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h02);
`ifdef MC_ADDI_EN
    legal = legal || (op == 6'h08);
`endif
    case (kind)
      K_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      K_DECODE: begin sb = 2'b11; ill = !legal; done = !legal; end
      K_MEMADR: begin sa = 1; sb = 2'b10; end
      K_MEMRD:  begin mr = 1; iord = 1; end
      K_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      K_MEMWR:  begin mw = 1; iord = 1; done = rdy; end
      K_EXEC:   begin sa = 1; aop = 2'b10; end
      K_RWB:    begin rw = 1; rd = 1; done = 1; end
      K_BRANCH: begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      K_JUMP:   begin pw = 1; psrc = 2'b10; done = 1; end
      K_ADDIEX: begin sa = 1; sb = 2'b10; end
      K_ADDIWB: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, psrc, ill, done};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.instr_done};
  endfunction

  // One clock cycle: drive inputs after the rising edge, queue the expected
  // control word for the state this cycle should be in, compare on the falling edge.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input int kind, input string tag);
    logic [17:0] obs;
    logic [17:0] exp;
    string       t;
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    exp_q.push_back(exp_vec(kind, rdy, op));
    tag_q.push_back(tag);
    @(negedge clk);
    obs = obs_vec();
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", t, obs, exp);
    end
    n_cmp++;
    assert ({bus.mem_read & bus.mem_write, bus.pc_write & bus.pc_write_cond} === 2'b00) else begin
      n_bad++;
      $error("FAIL %s_excl observed=%b expected=00", t,
             {bus.mem_read & bus.mem_write, bus.pc_write & bus.pc_write_cond});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset held, then R-type
    step(1'b0, 6'h00, 1'b1, K_RESET,  "rst_hold0");
    step(1'b0, 6'h00, 1'b1, K_RESET,  "rst_hold1");
    step(1'b1, 6'h00, 1'b1, K_RESET,  "rst_release");
    step(1'b1, 6'h00, 1'b1, K_FETCH,  "r_fetch");
    step(1'b1, 6'h00, 1'b1, K_DECODE, "r_decode");
    step(1'b1, 6'h00, 1'b1, K_EXEC,   "r_exec");
    step(1'b1, 6'h00, 1'b1, K_RWB,    "r_rwb");

    // lw with 3 stall cycles; opcode changes after DECODE to prove latching
    step(1'b1, 6'h23, 1'b1, K_FETCH,  "lw_fetch");
    step(1'b1, 6'h23, 1'b1, K_DECODE, "lw_decode");
    step(1'b1, 6'h2b, 1'b1, K_MEMADR, "lw_memadr");
    step(1'b1, 6'h2b, 1'b0, K_MEMRD,  "lw_stall0");
    step(1'b1, 6'h2b, 1'b0, K_MEMRD,  "lw_stall1");
    step(1'b1, 6'h2b, 1'b0, K_MEMRD,  "lw_stall2");
    step(1'b1, 6'h2b, 1'b1, K_MEMRD,  "lw_memrd");
    step(1'b1, 6'h2b, 1'b1, K_MEMWB,  "lw_memwb");

    // sw, beq, j back to back
    step(1'b1, 6'h2b, 1'b1, K_FETCH,  "sw_fetch");
    step(1'b1, 6'h2b, 1'b1, K_DECODE, "sw_decode");
    step(1'b1, 6'h2b, 1'b1, K_MEMADR, "sw_memadr");
    step(1'b1, 6'h2b, 1'b1, K_MEMWR,  "sw_memwr");
    step(1'b1, 6'h04, 1'b1, K_FETCH,  "beq_fetch");
    step(1'b1, 6'h04, 1'b1, K_DECODE, "beq_decode");
    step(1'b1, 6'h04, 1'b1, K_BRANCH, "beq_branch");
    step(1'b1, 6'h02, 1'b1, K_FETCH,  "j_fetch");
    step(1'b1, 6'h02, 1'b1, K_DECODE, "j_decode");
    step(1'b1, 6'h02, 1'b1, K_JUMP,   "j_jump");

    // Illegal opcode, then sw with fetch and store stalls
    step(1'b1, 6'h3f, 1'b1, K_FETCH,  "ill_fetch");
    step(1'b1, 6'h3f, 1'b1, K_DECODE, "ill_decode");
    step(1'b1, 6'h2b, 1'b0, K_FETCH,  "sws_fetch_stall");
    step(1'b1, 6'h2b, 1'b1, K_FETCH,  "sws_fetch");
    step(1'b1, 6'h2b, 1'b1, K_DECODE, "sws_decode");
    step(1'b1, 6'h00, 1'b1, K_MEMADR, "sws_memadr");
    step(1'b1, 6'h00, 1'b0, K_MEMWR,  "sws_stall");
    step(1'b1, 6'h00, 1'b1, K_MEMWR,  "sws_memwr");

    // addi
    step(1'b1, 6'h08, 1'b1, K_FETCH,  "addi_fetch");
    step(1'b1, 6'h08, 1'b1, K_DECODE, "addi_decode");
`ifdef MC_ADDI_EN
    step(1'b1, 6'h08, 1'b1, K_ADDIEX, "addi_ex");
    step(1'b1, 6'h08, 1'b1, K_ADDIWB, "addi_wb");
`endif

    // Reset while stalled in MEMRD
    step(1'b1, 6'h23, 1'b1, K_FETCH,  "mr_fetch");
    step(1'b1, 6'h23, 1'b1, K_DECODE, "mr_decode");
    step(1'b1, 6'h23, 1'b1, K_MEMADR, "mr_memadr");
    step(1'b1, 6'h23, 1'b0, K_MEMRD,  "mr_stall");
    step(1'b0, 6'h23, 1'b0, K_MEMRD,  "mr_rst_edge");
    step(1'b0, 6'h23, 1'b0, K_RESET,  "mr_reset");
    step(1'b1, 6'h23, 1'b1, K_RESET,  "mr_release");
    step(1'b1, 6'h23, 1'b1, K_FETCH,  "mr_fetch2");

    n_cmp++;
    assert (exp_q.size() === 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
